// File: rtl/stream_ctrl_pkg.sv
// Shared types and constants for the Dilithium output stream controllers.
`default_nettype none

package stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hD1;
  localparam logic [7:0] TRL_MAGIC = 8'hE0;

  localparam int FLAG_TIMEOUT      = 16;
  localparam int FLAG_EARLY_LAST   = 17;
  localparam int FLAG_MISSING_LAST = 18;
  localparam int FLAG_BAD_MODE     = 19;

  localparam logic [9:0] LEN_M0_L2 = 10'd480;
  localparam logic [9:0] LEN_M0_L3 = 10'd744;
  localparam logic [9:0] LEN_M0_L5 = 10'd932;
  localparam logic [9:0] LEN_M1    = 10'd1;
  localparam logic [9:0] LEN_M2_L2 = 10'd303;
  localparam logic [9:0] LEN_M2_L3 = 10'd412;
  localparam logic [9:0] LEN_M2_L5 = 10'd575;

endpackage

`default_nettype wire

// File: rtl/dilithium_output_size.sv
// Combinational lookup of the result length in words for a (mode, sec_lvl) pair.
`default_nettype none

module dilithium_output_size
  import stream_ctrl_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [2:0] sec_lvl,
  output logic [9:0] len,
  output logic       bad_mode
);

  always_comb begin
    len      = 10'd0;
    bad_mode = 1'b0;
    case (mode)
      2'd0: begin
        case (sec_lvl)
          3'd2:    len = LEN_M0_L2;
          3'd3:    len = LEN_M0_L3;
          default: len = LEN_M0_L5;
        endcase
      end
      2'd1: len = LEN_M1;
      2'd2: begin
        case (sec_lvl)
          3'd2:    len = LEN_M2_L2;
          3'd3:    len = LEN_M2_L3;
          default: len = LEN_M2_L5;
        endcase
      end
      default: bad_mode = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/output_frame_scheduler.sv
// Frames one Dilithium result as header, pass-through payload and status trailer,
// policing the upstream stream for stalls and length mismatches.
`default_nettype none

module output_frame_scheduler
  import stream_ctrl_pkg::*;
#(
  parameter int w       = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [2:0]   sec_lvl,
  output logic         busy,
  output logic         done,
  output logic         error,
  input  logic         src_valid,
  output logic         src_ready,
  input  logic [w-1:0] src_data,
  input  logic         src_last,
  output logic         valid_o,
  input  logic         ready_o,
  output logic [w-1:0] data_o,
  output logic         last
);

  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t state, state_next;

  logic [1:0]        mode_q;
  logic [2:0]        sec_q;
  logic [9:0]        exp_len;
  logic [9:0]        cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              flag_timeout;
  logic              flag_early_last;
  logic              flag_missing_last;
  logic              flag_bad_mode;
  logic              done_q;

  logic [9:0] size_len;
  logic       size_bad;

  dilithium_output_size u_size (
    .mode     (mode),
    .sec_lvl  (sec_lvl),
    .len      (size_len),
    .bad_mode (size_bad)
  );

  logic [9:0] last_idx;
  logic       beat;
  logic       at_end;
  logic       idle_expire;

  // exp_len is never 0 while in PAYLOAD, so last_idx cannot underflow there.
  assign last_idx    = exp_len - 10'd1;
  assign beat        = (state == ST_PAYLOAD) && src_valid && ready_o;
  assign at_end      = (cnt == last_idx);
  assign idle_expire = (state == ST_PAYLOAD) && !beat
                       && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  assign busy  = (state != ST_IDLE);
  assign done  = done_q;
  assign error = flag_timeout | flag_early_last | flag_missing_last | flag_bad_mode;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    valid_o    = 1'b0;
    src_ready  = 1'b0;
    data_o     = '0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_HEADER;
      end
      ST_HEADER: begin
        valid_o            = 1'b1;
        data_o[w-1 -: 8]   = HDR_MAGIC;
        data_o[15:13]      = sec_q;
        data_o[12:11]      = mode_q;
        data_o[9:0]        = exp_len;
        if (ready_o) state_next = flag_bad_mode ? ST_TRAILER : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        valid_o   = src_valid;
        src_ready = ready_o;
        data_o    = src_data;
        if ((beat && (at_end || src_last)) || idle_expire) state_next = ST_TRAILER;
      end
      ST_TRAILER: begin
        valid_o                   = 1'b1;
        last                      = 1'b1;
        data_o[w-1 -: 8]          = TRL_MAGIC;
        data_o[9:0]               = cnt;
        data_o[FLAG_TIMEOUT]      = flag_timeout;
        data_o[FLAG_EARLY_LAST]   = flag_early_last;
        data_o[FLAG_MISSING_LAST] = flag_missing_last;
        data_o[FLAG_BAD_MODE]     = flag_bad_mode;
        if (ready_o) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q            <= 2'd0;
      sec_q             <= 3'd0;
      exp_len           <= 10'd0;
      cnt               <= 10'd0;
      idle_cnt          <= '0;
      flag_timeout      <= 1'b0;
      flag_early_last   <= 1'b0;
      flag_missing_last <= 1'b0;
      flag_bad_mode     <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      done_q <= (state == ST_TRAILER) && ready_o;
      if (state == ST_IDLE && start) begin
        mode_q            <= mode;
        sec_q             <= sec_lvl;
        exp_len           <= size_len;
        flag_bad_mode     <= size_bad;
        cnt               <= 10'd0;
        idle_cnt          <= '0;
        flag_timeout      <= 1'b0;
        flag_early_last   <= 1'b0;
        flag_missing_last <= 1'b0;
      end else if (state == ST_PAYLOAD) begin
        // A beat always wins over an expiring idle counter.
        if (beat) begin
          cnt      <= cnt + 10'd1;
          idle_cnt <= '0;
          if (at_end && !src_last)  flag_missing_last <= 1'b1;
          if (!at_end && src_last)  flag_early_last   <= 1'b1;
        end else if (idle_expire) begin
          flag_timeout <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_output_frame_scheduler.sv
// Directed self-checking bench for output_frame_scheduler.
`default_nettype none

module tb_output_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [2:0]  sec_lvl;
  logic        busy, done, error;
  logic        src_valid, src_ready, src_last;
  logic [63:0] src_data;
  logic        valid_o, ready_o, last;
  logic [63:0] data_o;

  int checks = 0;
  int errors = 0;

  output_frame_scheduler #(.w(64), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .sec_lvl   (sec_lvl),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .src_last  (src_last),
    .valid_o   (valid_o),
    .ready_o   (ready_o),
    .data_o    (data_o),
    .last      (last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [15:0] v;
    v = i[15:0];
    return {16'hBEEF, v, 16'hF00D, ~v};
  endfunction

  function automatic logic [63:0] hdr_word(input logic [1:0] m, input logic [2:0] s,
                                           input logic [9:0] len);
    return {8'hD1, 40'd0, s, m, 1'b0, len};
  endfunction

  // flags: bit0 timeout, bit1 early_last, bit2 missing_last, bit3 bad_mode
  function automatic logic [63:0] trl_word(input logic [9:0] c, input logic [3:0] flags);
    return {8'hE0, 36'd0, flags, 6'd0, c};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_error"},     64'(error),     64'd0);
    check({tag, "_valid_o"},   64'(valid_o),   64'd0);
    check({tag, "_src_ready"}, 64'(src_ready), 64'd0);
    check({tag, "_last"},      64'(last),      64'd0);
    check({tag, "_data_o"},    data_o,         64'd0);
  endtask

  // Entered and left at one time unit after a rising edge.
  task automatic run_frame(input logic [1:0] m, input logic [2:0] s, input int n_words,
                           input int last_pos, input bit stall, input bit poke,
                           input logic [9:0] len_e, input logic [9:0] cnt_e,
                           input logic [3:0] flags_e, input logic err_e);
    int idx   = 0;
    int phase = 0;
    int hold  = 0;
    int cyc   = 0;
    bit fin   = 0;
    start = 1'b1; mode = m; sec_lvl = s;
    @(posedge clk); #1;
    // Poking start with a different config must not disturb the latched one.
    start = poke; mode = 2'd0; sec_lvl = 3'd2;
    check("start_busy",  64'(busy),    64'd1);
    check("start_valid", 64'(valid_o), 64'd1);
    check("start_error", 64'(error),   64'(m == 2'd3));
    while (!fin && cyc < 4000) begin
      src_valid = (idx < n_words) && (!stall || $urandom_range(0, 3) != 0);
      src_data  = pat(idx);
      src_last  = (last_pos != 0) && (idx + 1 == last_pos);
      if (stall && phase >= 1 && idx >= int'(cnt_e) && hold < 3) ready_o = 1'b0;
      else ready_o = !stall || ($urandom_range(0, 3) != 0);
      #1;
      if (phase == 1 && valid_o && last) phase = 2;
      case (phase)
        0: begin
          check("hdr_valid",     64'(valid_o),   64'd1);
          check("hdr_src_ready", 64'(src_ready), 64'd0);
          if (ready_o) begin
            check("header",   data_o,     hdr_word(m, s, len_e));
            check("hdr_last", 64'(last),  64'd0);
            phase = 1;
          end
        end
        1: begin
          check("pay_ready", 64'(src_ready), 64'(ready_o));
          if (src_valid && ready_o) begin
            check("pay_valid", 64'(valid_o), 64'd1);
            check("pay_data",  data_o,       pat(idx));
            check("pay_last",  64'(last),    64'd0);
            idx++;
          end
        end
        default: begin
          check("trl_valid",     64'(valid_o),   64'd1);
          check("trl_src_ready", 64'(src_ready), 64'd0);
          check("trailer",       data_o,         trl_word(cnt_e, flags_e));
          if (ready_o) fin = 1;
          else hold++;
        end
      endcase
      @(posedge clk); #1;
      cyc++;
    end
    check("frame_budget", 64'(fin), 64'd1);
    start = 1'b0; src_valid = 1'b0; src_last = 1'b0; ready_o = 1'b0;
    #1;
    check("done_pulse",  64'(done),    64'd1);
    check("done_busy",   64'(busy),    64'd0);
    check("done_valid",  64'(valid_o), 64'd0);
    check("frame_error", 64'(error),   64'(err_e));
    check("beats",       64'(idx),     64'(cnt_e));
    @(posedge clk); #1;
    check("done_once", 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; sec_lvl = 3'd0;
    src_valid = 1'b0; src_data = 64'd0; src_last = 1'b0; ready_o = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(2'd0, 3'd2, 480, 480, 1'b0, 1'b0, 10'd480, 10'd480, 4'b0000, 1'b0);
    run_frame(2'd2, 3'd5, 575, 575, 1'b1, 1'b0, 10'd575, 10'd575, 4'b0000, 1'b0);
    run_frame(2'd1, 3'd2, 1,   0,   1'b0, 1'b1, 10'd1,   10'd1,   4'b0100, 1'b1);
    run_frame(2'd0, 3'd3, 200, 100, 1'b0, 1'b0, 10'd744, 10'd100, 4'b0010, 1'b1);
    run_frame(2'd3, 3'd2, 5,   0,   1'b0, 1'b0, 10'd0,   10'd0,   4'b1000, 1'b1);
    run_frame(2'd0, 3'd2, 10,  0,   1'b0, 1'b0, 10'd480, 10'd10,  4'b0001, 1'b1);

    // Abandon a frame mid-payload with reset while upstream keeps offering data.
    start = 1'b1; mode = 2'd0; sec_lvl = 3'd2;
    @(posedge clk); #1;
    start = 1'b0; src_valid = 1'b1; ready_o = 1'b1;
    for (int i = 0; i < 6; i++) begin
      src_data = pat(i);
      @(posedge clk); #1;
    end
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("rst_mid");
    rst = 1'b0; src_valid = 1'b0; ready_o = 1'b0;
    @(posedge clk); #1;
    check("rst_idle", 64'(busy), 64'd0);

    run_frame(2'd1, 3'd3, 1, 1, 1'b0, 1'b0, 10'd1, 10'd1, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/output_frame_scheduler.md
# output_frame_scheduler

Controller that sequences one Dilithium result onto the external output stream as a framed packet: a header word, the payload words drained from the stream adapter, then a status trailer word. It sits between the stream adapter's external port and the chip-level output interface. It owns the job lifecycle (`start`/`busy`/`done`), computes the expected payload length from mode and security level, and polices the upstream stream for stalls and length mismatches.

## Interface
Parameters:
- `w`, default 64: data width; must be ≥ 64.
- `TIMEOUT`, default 4096: number of consecutive PAYLOAD cycles without an upstream beat before the frame is aborted.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: single-cycle job start. Ignored unless the FSM is in IDLE.
- `mode`, in, 2: operation mode. Sampled on an accepted `start`.
- `sec_lvl`, in, 3: security level (2, 3 or 5). Sampled on an accepted `start`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when the trailer word transfers.
- `error`, out, 1: sticky per frame. Set when any trailer flag is set; cleared on the next accepted `start`.
- `src_valid`, in, 1: upstream valid, from the stream adapter.
- `src_ready`, out, 1: upstream ready.
- `src_data`, in, w: upstream data.
- `src_last`, in, 1: upstream last.
- `valid_o`, out, 1: downstream valid.
- `ready_o`, in, 1: downstream ready.
- `data_o`, out, w: downstream data.
- `last`, out, 1: downstream last. Asserted only on the trailer word.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, TRAILER.
- IDLE → HEADER on `start`. In the same edge: latch `mode`/`sec_lvl`, load `exp_len`, clear `cnt`, the flags and `error`.
- `exp_len` (10 bits) lookup:
  - mode 0: 480 / 744 / 932 for sec_lvl 2 / 3 / other.
  - mode 1: 1.
  - mode 2: 303 / 412 / 575 for sec_lvl 2 / 3 / other.
  - mode 3: 0, and set flag `bad_mode`.
- HEADER word:
  - `data_o[w-1:w-8]` = 8'hD1.
  - `[12:11]` = mode.
  - `[15:13]` = sec_lvl.
  - `[9:0]` = `exp_len`.
  - All other bits 0.
- HEADER → PAYLOAD on `valid_o && ready_o`. If `bad_mode`, HEADER → TRAILER instead.
- PAYLOAD is a combinational pass-through:
  - `valid_o = src_valid`, `src_ready = ready_o`, `data_o = src_data`, `last = 0`.
  - Each beat (`src_valid && ready_o`) increments `cnt`.
- PAYLOAD exits to TRAILER on the first of these events:
  - Beat with `cnt == exp_len-1`: normal exit. If `src_last == 0` on that beat, set `missing_last`.
  - Beat with `src_last == 1` and `cnt < exp_len-1`: set `early_last`.
  - Idle counter reaches `TIMEOUT-1` with no beat: set `timeout`. The counter resets on every beat.
- TRAILER word:
  - `[w-1:w-8]` = 8'hE0.
  - `[9:0]` = final `cnt`, including the exiting beat.
  - Flags: `[16]` timeout, `[17]` early_last, `[18]` missing_last, `[19]` bad_mode.
  - `last = 1`.
- TRAILER → IDLE on transfer, pulsing `done`.
- `src_ready = 0` in every state except PAYLOAD. Upstream words arriving outside PAYLOAD are never consumed.
- Arithmetic: `cnt` and `exp_len` are 10 bits and never wrap (max 932 < 1024). The idle counter is `$clog2(TIMEOUT)` bits and saturates.

## Timing
- Reset values: `busy`, `done`, `error`, `valid_o`, `src_ready`, `last` = 0; `data_o` = 0; FSM in IDLE. All counters and flags = 0.
- `start` at edge N: `busy` and `valid_o` (header) are high after edge N. Latency from start to header valid is 1 cycle.
- HEADER and TRAILER hold `valid_o` and `data_o` stable until `ready_o`. No combinational path from `ready_o` to `valid_o`.
- PAYLOAD adds zero latency. Throughput is 1 word/cycle.
- `done` is high for the single cycle after the trailer-transfer edge, coincident with `busy` = 0.
- `start` while busy: ignored, with no effect on the latched config.
- `start` in the same cycle the trailer transfers: ignored. The next `start` is accepted from IDLE.
- `rst` at any point, including mid-PAYLOAD: all outputs return to reset values on the next edge. A partial frame is abandoned with no trailer.
- Timeout and a beat in the same cycle: the beat wins and the idle counter resets.

## Structure
- Package `stream_ctrl_pkg` holds:
  - The state enum.
  - Magic constants `HDR_MAGIC`/`TRL_MAGIC`.
  - Trailer flag bit positions.
  - The output-length constants (480, 744, 932, 1, 303, 412, 575).
- Sub-module `dilithium_output_size`: combinational lookup of (`mode`, `sec_lvl`) → (`len[9:0]`, `bad_mode`). The stream adapter uses the same sub-module.
- Counters are inline. The FSM is a single `always_ff` plus output `always_comb`.

## Test plan
- mode 0, sec_lvl 2, upstream 480 words with `src_last` on word 480, `ready_o` = 1 → header `exp_len` = 480, 480 payload beats, trailer cnt = 480, flags 0, `last` on trailer only, `done` pulse.
- mode 2, sec_lvl 5, random `ready_o`/`src_valid` stalls → 575 words delivered in order, with no drops or duplicates. The trailer is stable during stalls.
- mode 1 with `src_last` missing → trailer cnt = 1, `missing_last` = 1, `error` = 1.
- mode 0, sec_lvl 3, `src_last` on word 100 → trailer cnt = 100, `early_last` = 1.
- mode 3 → header `exp_len` = 0, `src_ready` never high, trailer `bad_mode` = 1.
- `TIMEOUT` = 16, upstream stops after 10 words → trailer at cnt = 10, `timeout` = 1. `rst` asserted mid-PAYLOAD in a second run → all outputs at reset values the next cycle.
